// File: rtl/fir_pkg.sv
// Shared constants, coefficient ROM, fixed-point helpers and FSM state type for the channel FIR.
// FIR_CHANNEL_SAT_EN selects 4 guard bits on the accumulators for the saturating build.
package fir_pkg;
  localparam int DATA_SIZE = 32;
  localparam int BITS      = 10;
  localparam int TAPS      = 20;
  localparam int TAP_W     = $clog2(TAPS);
  localparam int PROD_W    = 2 * DATA_SIZE;
`ifdef FIR_CHANNEL_SAT_EN
  localparam int ACC_W     = DATA_SIZE + 4;
`else
  localparam int ACC_W     = DATA_SIZE;
`endif

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } fir_state_t;

  // Symmetric low-pass, quantized with BITS fractional bits (sum = 2806).
  localparam logic signed [DATA_SIZE-1:0] CHANNEL_COEFFS [TAPS] = '{
    32'sd10,  32'sd25,  32'sd48,  32'sd80,  32'sd118,
    32'sd160, 32'sd200, 32'sd234, 32'sd258, 32'sd270,
    32'sd270, 32'sd258, 32'sd234, 32'sd200, 32'sd160,
    32'sd118, 32'sd80,  32'sd48,  32'sd25,  32'sd10
  };

  function automatic logic signed [DATA_SIZE-1:0] DEQUANTIZE(input logic signed [PROD_W-1:0] p);
    return DATA_SIZE'(p >>> BITS);
  endfunction

  function automatic logic signed [DATA_SIZE-1:0] QUANTIZE(input logic signed [DATA_SIZE-1:0] v);
    return v <<< BITS;
  endfunction
endpackage

// File: rtl/fir_mac_lane.sv
// One channel lane: sample history, sequential tap multiply and accumulator, output register.
// Latency: one tap per mac_en cycle; result registered on out_ld (saturated when FIR_CHANNEL_SAT_EN).
// Backpressure: none locally; the control FSM holds out_ld/shift_en while outputs are blocked.
module fir_mac_lane
  import fir_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        shift_en,
  input  logic                        acc_clr,
  input  logic                        mac_en,
  input  logic                        out_ld,
  input  logic                        out_zero,
  input  logic [TAP_W-1:0]            tap,
  input  logic signed [DATA_SIZE-1:0] din,
  output logic signed [DATA_SIZE-1:0] dout
);
  logic signed [DATA_SIZE-1:0] x [TAPS];
  logic signed [DATA_SIZE-1:0] coef;
  logic signed [DATA_SIZE-1:0] xv;
  logic signed [PROD_W-1:0]    prod;
  logic signed [DATA_SIZE-1:0] term;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     acc_nxt;
  logic signed [DATA_SIZE-1:0] result;

  assign coef    = CHANNEL_COEFFS[tap];
  assign xv      = x[tap];
  assign prod    = PROD_W'(coef) * PROD_W'(xv);
  assign term    = DEQUANTIZE(prod);
  assign acc_nxt = acc + ACC_W'(term);

`ifdef FIR_CHANNEL_SAT_EN
  localparam logic signed [DATA_SIZE-1:0] DMAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [DATA_SIZE-1:0] DMIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

  always_comb begin
    result = acc_nxt[DATA_SIZE-1:0];
    if (acc_nxt > ACC_W'(DMAX))
      result = DMAX;
    else if (acc_nxt < ACC_W'(DMIN))
      result = DMIN;
  end
`else
  assign result = acc_nxt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      acc  <= '0;
      dout <= '0;
    end else begin
      if (shift_en) begin
        x[0] <= din;
        for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
      end
      if (acc_clr)
        acc <= '0;
      else if (mac_en)
        acc <= acc_nxt;
      // out_ld fires on the last tap, so the final product is folded in via acc_nxt
      if (out_zero)
        dout <= '0;
      else if (out_ld)
        dout <= result;
    end
  end
endmodule

// File: rtl/fir_channel_cmplx.sv
// Complex channel-select FIR with decimation by DECIM; FIR_CHANNEL_SAT_EN enables output saturation.
// Latency: TAPS+1 cycles from the last input pop to out_wr_en; one output per DECIM+TAPS+1 cycles at best.
// Backpressure: reads only when both input FIFOs are non-empty; holds results in WRITE until both outputs have room.
module fir_channel_cmplx
  import fir_pkg::*;
#(
  parameter int DECIM = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] i_in,
  input  logic [DATA_SIZE-1:0] q_in,
  input  logic                 i_in_empty,
  input  logic                 q_in_empty,
  output logic                 in_rd_en,
  input  logic                 i_out_full,
  input  logic                 q_out_full,
  output logic                 out_wr_en,
  output logic [DATA_SIZE-1:0] i_out,
  output logic [DATA_SIZE-1:0] q_out
);
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  fir_state_t       state;
  logic [TAP_W-1:0] tap;
  logic [CNT_W-1:0] cnt;
  logic             last_tap;
  logic             last_cnt;
  logic             acc_clr;
  logic             mac_en;
  logic             out_ld;
  logic             state_bad;

  assign last_tap  = (tap == TAP_W'(TAPS - 1));
  assign last_cnt  = (cnt == CNT_W'(DECIM - 1));
  assign state_bad = !(state == SHIFT || state == MAC || state == WRITE);
  // Reset gates the strobes so no FIFO sees a pop or push during the reset cycle
  assign in_rd_en  = !reset && (state == SHIFT) && !i_in_empty && !q_in_empty;
  assign out_wr_en = !reset && (state == WRITE) && !i_out_full && !q_out_full;
  assign acc_clr   = in_rd_en && last_cnt;
  assign mac_en    = (state == MAC);
  assign out_ld    = mac_en && last_tap;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SHIFT;
      tap   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        SHIFT: begin
          if (in_rd_en) begin
            if (last_cnt) begin
              cnt   <= '0;
              tap   <= '0;
              state <= MAC;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        MAC: begin
          if (last_tap)
            state <= WRITE;
          else
            tap <= tap + TAP_W'(1);
        end
        WRITE: begin
          if (out_wr_en)
            state <= SHIFT;
        end
        default: state <= SHIFT;
      endcase
    end
  end

  fir_mac_lane u_lane_i (
    .clock    (clock),
    .reset    (reset),
    .shift_en (in_rd_en),
    .acc_clr  (acc_clr),
    .mac_en   (mac_en),
    .out_ld   (out_ld),
    .out_zero (state_bad),
    .tap      (tap),
    .din      (i_in),
    .dout     (i_out)
  );

  fir_mac_lane u_lane_q (
    .clock    (clock),
    .reset    (reset),
    .shift_en (in_rd_en),
    .acc_clr  (acc_clr),
    .mac_en   (mac_en),
    .out_ld   (out_ld),
    .out_zero (state_bad),
    .tap      (tap),
    .din      (q_in),
    .dout     (q_out)
  );
endmodule

// File: tb/tb_fir_channel_cmplx.sv
// Directed, table-driven bench for fir_channel_cmplx (DECIM=1 and DECIM=4 instances).
module tb_fir_channel_cmplx;
  typedef struct {
    logic [31:0] i_in;
    logic [31:0] q_in;
    logic [31:0] exp_i;
    logic [31:0] exp_q;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [31:0] i_in, q_in, i_out, q_out;
  logic        i_in_empty, q_in_empty, in_rd_en, i_out_full, q_out_full, out_wr_en;
  logic [31:0] i_in4, q_in4, i_out4, q_out4;
  logic        i_in_empty4, q_in_empty4, in_rd_en4, out_wr_en4;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_total = 0;
  int rd4_total = 0;
  int first_rd = -1;
  int first_wr = -1;
  logic block_q = 1'b0;
  logic [31:0] pi[$], pq[$], p4[$];
  logic [31:0] oi[$], oq[$], o4[$], o4q[$];
  int rd4_at_wr[$];

  int coef [20] = '{10, 25, 48, 80, 118, 160, 200, 234, 258, 270,
                    270, 258, 234, 200, 160, 118, 80, 48, 25, 10};
  vec_t imp [20];
  vec_t mix [4];

  fir_channel_cmplx #(.DECIM(1)) dut (
    .clock(clock), .reset(reset), .i_in(i_in), .q_in(q_in),
    .i_in_empty(i_in_empty), .q_in_empty(q_in_empty), .in_rd_en(in_rd_en),
    .i_out_full(i_out_full), .q_out_full(q_out_full), .out_wr_en(out_wr_en),
    .i_out(i_out), .q_out(q_out)
  );

  fir_channel_cmplx #(.DECIM(4)) dut4 (
    .clock(clock), .reset(reset), .i_in(i_in4), .q_in(q_in4),
    .i_in_empty(i_in_empty4), .q_in_empty(q_in_empty4), .in_rd_en(in_rd_en4),
    .i_out_full(1'b0), .q_out_full(1'b0), .out_wr_en(out_wr_en4),
    .i_out(i_out4), .q_out(q_out4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", name, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic drive();
    i_in        = (pi.size() > 0) ? pi[0] : 32'd0;
    q_in        = (pq.size() > 0) ? pq[0] : 32'd0;
    i_in_empty  = (pi.size() == 0);
    q_in_empty  = (pq.size() == 0) || block_q;
    i_in4       = (p4.size() > 0) ? p4[0] : 32'd0;
    q_in4       = 32'd0;
    i_in_empty4 = (p4.size() == 0);
    q_in_empty4 = (p4.size() == 0);
  endtask

  // One clock: sample at the falling edge, advance the FIFO models just after the rising edge.
  task automatic step();
    logic pop, pop4;
    @(negedge clock);
    cyc++;
    pop  = in_rd_en;
    pop4 = in_rd_en4;
    if (in_rd_en) begin
      rd_total++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (out_wr_en) begin
      oi.push_back(i_out);
      oq.push_back(q_out);
      if (first_wr < 0) first_wr = cyc;
    end
    if (in_rd_en4) rd4_total++;
    if (out_wr_en4) begin
      o4.push_back(i_out4);
      o4q.push_back(q_out4);
      rd4_at_wr.push_back(rd4_total);
    end
    @(posedge clock);
    #1;
    if (pop) begin
      void'(pi.pop_front());
      void'(pq.pop_front());
    end
    if (pop4) void'(p4.pop_front());
    drive();
  endtask

  task automatic wait_outs(input int n, input string name);
    int k = 0;
    while (oi.size() < n && k < 2000) begin
      step();
      k++;
    end
    check(name, oi.size(), n);
  endtask

  task automatic wait_rd(input int prev);
    int k = 0;
    while (rd_total == prev && k < 100) begin
      step();
      k++;
    end
    check("rd_seen", rd_total, prev + 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push_vecs(input vec_t v [], input int n);
    for (int k = 0; k < n; k++) begin
      pi.push_back(v[k].i_in);
      pq.push_back(v[k].q_in);
    end
    drive();
  endtask

  initial begin
    int base;
    int rd0;

    for (int k = 0; k < 20; k++) begin
      imp[k].i_in  = (k == 0) ? 32'd1024 : 32'd0;
      imp[k].q_in  = 32'd0;
      imp[k].exp_i = 32'(coef[k]);
      imp[k].exp_q = 32'd0;
    end
    mix[0] = '{-32'sd1024, 32'sd2048, -32'sd10, 32'sd20};
    mix[1] = '{32'd0,      32'd0,     -32'sd25, 32'sd50};
    mix[2] = '{-32'sd1,    32'sd512,  -32'sd49, 32'sd101};
    mix[3] = '{32'd0,      32'd0,     -32'sd81, 32'sd172};

    reset = 1'b1;
    i_out_full = 1'b0;
    q_out_full = 1'b0;
    drive();
    push_vecs(imp, 20);
    repeat (3) step();
    @(negedge clock);
    check("rst_i_out", i_out, 32'd0);
    check("rst_q_out", q_out, 32'd0);
    check("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
    check("rst_rd_cnt", rd_total, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Impulse: outputs reproduce the coefficient ROM
    wait_outs(20, "imp_count");
    for (int k = 0; k < 20; k++) begin
      check($sformatf("imp_i[%0d]", k), oi[k], imp[k].exp_i);
      check($sformatf("imp_q[%0d]", k), oq[k], imp[k].exp_q);
    end
    check("latency", first_wr - first_rd, 21);

    // Signed, scaled and truncating inputs continuing from the impulse history
    push_vecs(mix, 4);
    wait_outs(24, "mix_count");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mix_i[%0d]", k), oi[20+k], mix[k].exp_i);
      check($sformatf("mix_q[%0d]", k), oq[20+k], mix[k].exp_q);
    end

    // Unbalanced inputs: I available, Q empty
    rd0 = rd_total;
    block_q = 1'b1;
    pi.push_back(32'd0);
    pq.push_back(32'd0);
    drive();
    repeat (10) step();
    check("unbal_no_read", rd_total, rd0);
    block_q = 1'b0;
    drive();
    wait_outs(25, "unbal_count");
    check("unbal_one_read", rd_total, rd0 + 1);

    // Backpressure in WRITE
    do_reset();
    base = oi.size();
    q_out_full = 1'b1;
    pi.push_back(32'd1024);
    pq.push_back(-32'sd1024);
    drive();
    wait_rd(rd_total);
    repeat (21) step();
    for (int k = 0; k < 7; k++) begin
      step();
      check("bp_no_write", oi.size(), base);
      check("bp_i_stable", i_out, 32'd10);
      check("bp_q_stable", q_out, -32'sd10);
    end
    q_out_full = 1'b0;
    step();
    check("bp_write_now", oi.size(), base + 1);
    repeat (25) step();
    check("bp_one_write", oi.size(), base + 1);
    check("bp_val_i", oi[base], 32'd10);
    check("bp_val_q", oq[base], -32'sd10);

    // Reset during MAC at tap 5 discards the result
    do_reset();
    base = oi.size();
    pi.push_back(32'd1024);
    pq.push_back(32'd0);
    drive();
    wait_rd(rd_total);
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (40) step();
    check("mid_rst_no_write", oi.size(), base);
    push_vecs(imp, 20);
    wait_outs(base + 20, "rerun_count");
    for (int k = 0; k < 20; k++)
      check($sformatf("rerun_i[%0d]", k), oi[base+k], imp[k].exp_i);

    // DECIM=4 instance, constant 1.0 on I
    for (int k = 0; k < 40; k++) p4.push_back(32'd1024);
    drive();
    begin
      int k = 0;
      while (o4.size() < 10 && k < 2000) begin
        step();
        k++;
      end
    end
    check("d4_count", o4.size(), 10);
    if (o4.size() >= 10) begin
      check("d4_first", o4[0], 32'd163);
      check("d4_q", o4q[9], 32'd0);
      for (int k = 0; k < 10; k++)
        check($sformatf("d4_reads[%0d]", k), rd4_at_wr[k], 4 * (k + 1));
      for (int k = 4; k < 10; k++)
        check($sformatf("d4_steady[%0d]", k), o4[k], 32'd2806);
    end

`ifdef FIR_CHANNEL_SAT_EN
    do_reset();
    base = oi.size();
    for (int k = 0; k < 20; k++) begin
      pi.push_back(32'h7FFF_FFFF);
      pq.push_back(32'h8000_0000);
    end
    drive();
    wait_outs(base + 20, "sat_count");
    check("sat_pos", oi[base+19], 32'h7FFF_FFFF);
    check("sat_neg", oq[base+19], 32'h8000_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
